// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg
// Shared constants for the SPI register controller: register addresses,
// command byte field positions, reset defaults and the frame parser states.
package spi_reg_pkg;

  // Register map
  localparam logic [3:0] ADDR_FREQ1  = 4'd0;
  localparam logic [3:0] ADDR_FREQ2  = 4'd1;
  localparam logic [3:0] ADDR_PHASE1 = 4'd2;
  localparam logic [3:0] ADDR_PHASE2 = 4'd3;
  localparam logic [3:0] ADDR_TRISYM = 4'd4;
  localparam logic [3:0] ADDR_CTRL   = 4'd5;
  localparam logic [3:0] ADDR_ID     = 4'd6;

  // Command byte layout: bit7 selects write, low nibble is the address
  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_ADDR_MSB  = 3;

  // Number of data bytes carried by every frame
  localparam int DATA_BYTES = 4;

  // Reset defaults
  localparam logic [31:0] DEF_FREQ = 32'd2147483;
  localparam logic [31:0] DEF_SYM  = 32'd154748364;
  localparam logic [31:0] DEF_ID   = 32'h44504F31;
  localparam logic [7:0]  DEF_CTRL = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } state_t;

  // Only the first six addresses hold writable registers; ID and the
  // unmapped space accept a frame but never commit.
  function automatic logic is_writable(input logic [3:0] addr);
    return addr <= ADDR_CTRL;
  endfunction

endpackage

// File: rtl/spi_reg_bank.sv
// spi_reg_bank
// Live register file feeding the DDS channels. Written only through the
// single commit port, so every output word changes in one clock edge.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   we            commit strobe; wr_addr/wr_data select target and value
//   rd_addr       read address, rd_data returns the live value (0 if unmapped)
//   freq_word1/2, phase_word1/2, triangle_sym, ctrl   live register outputs
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int              FW_W         = 32,
  parameter logic [FW_W-1:0] FREQ_DEFAULT = DEF_FREQ,
  parameter logic [FW_W-1:0] SYM_DEFAULT  = DEF_SYM,
  parameter logic [FW_W-1:0] ID_VALUE     = DEF_ID
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [3:0]      wr_addr,
  input  logic [FW_W-1:0] wr_data,
  input  logic [3:0]      rd_addr,
  output logic [FW_W-1:0] rd_data,
  output logic [FW_W-1:0] freq_word1,
  output logic [FW_W-1:0] freq_word2,
  output logic [FW_W-1:0] phase_word1,
  output logic [FW_W-1:0] phase_word2,
  output logic [FW_W-1:0] triangle_sym,
  output logic [7:0]      ctrl
);

  always_ff @(posedge clk) begin
    if (rst) begin
      freq_word1   <= FREQ_DEFAULT;
      freq_word2   <= FREQ_DEFAULT;
      phase_word1  <= '0;
      phase_word2  <= '0;
      triangle_sym <= SYM_DEFAULT;
      ctrl         <= DEF_CTRL;
    end else if (we) begin
      case (wr_addr)
        ADDR_FREQ1:  freq_word1   <= wr_data;
        ADDR_FREQ2:  freq_word2   <= wr_data;
        ADDR_PHASE1: phase_word1  <= wr_data;
        ADDR_PHASE2: phase_word2  <= wr_data;
        ADDR_TRISYM: triangle_sym <= wr_data;
        ADDR_CTRL:   ctrl         <= wr_data[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_FREQ1:  rd_data = freq_word1;
      ADDR_FREQ2:  rd_data = freq_word2;
      ADDR_PHASE1: rd_data = phase_word1;
      ADDR_PHASE2: rd_data = phase_word2;
      ADDR_TRISYM: rd_data = triangle_sym;
      ADDR_CTRL:   rd_data[7:0] = ctrl;
      ADDR_ID:     rd_data = ID_VALUE;
      default:     rd_data = '0;
    endcase
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl
// Parses SPI byte frames (command byte + 4 data bytes, MSB first) into
// register writes and readbacks. Write data is staged and only committed to
// the register bank when chip select drops after a complete frame.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   cs_active         synchronised chip select
//   rx_byte/rx_valid  received byte and its one-cycle strobe
//   tx_byte           byte returned on the next SPI transfer
//   freq_word1/2, phase_word1/2, triangle_sym, ctrl   DDS control words
//   upd               pulse on the cycle a commit lands
//   frame_err         pulse after a frame aborted mid-data
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int              FW_W         = 32,
  parameter logic [FW_W-1:0] FREQ_DEFAULT = DEF_FREQ,
  parameter logic [FW_W-1:0] SYM_DEFAULT  = DEF_SYM,
  parameter logic [FW_W-1:0] ID_VALUE     = DEF_ID
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cs_active,
  input  logic [7:0]      rx_byte,
  input  logic            rx_valid,
  output logic [7:0]      tx_byte,
  output logic [FW_W-1:0] freq_word1,
  output logic [FW_W-1:0] freq_word2,
  output logic [FW_W-1:0] phase_word1,
  output logic [FW_W-1:0] phase_word2,
  output logic [FW_W-1:0] triangle_sym,
  output logic [7:0]      ctrl,
  output logic            upd,
  output logic            frame_err
);

  state_t          state_q, state_d;
  logic            cs_prev;
  logic            cs_rise, cs_fall, byte_evt;
  logic            cmd_write;
  logic [3:0]      cmd_addr;
  logic [1:0]      count;
  logic [FW_W-1:0] staging;
  logic [FW_W-1:0] tx_shift;
  logic [FW_W-1:0] rd_data;
  logic            sticky_err;
  logic            commit, abort;

  assign cs_rise  = cs_active && !cs_prev;
  assign cs_fall  = !cs_active && cs_prev;
  assign byte_evt = rx_valid && cs_active;

  assign commit = cs_fall && (state_q == ST_DONE) && cmd_write && is_writable(cmd_addr);
  assign abort  = cs_fall && (state_q == ST_DATA);

  // Readback bytes are only meaningful inside a frame; otherwise report the
  // error flag so the host can poll it with a bare transfer.
  assign tx_byte = (state_q == ST_DATA || state_q == ST_DONE) ?
                   tx_shift[FW_W-1 -: 8] : {7'b0, sticky_err};

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!cs_active) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_rise) state_d = ST_CMD;
        ST_CMD:  if (byte_evt) state_d = ST_DATA;
        ST_DATA: if (byte_evt && count == 2'(DATA_BYTES - 1)) state_d = ST_DONE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // cs_prev resets high so a chip select that is already asserted when reset
  // releases is not mistaken for a new frame; the interrupted frame is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_prev    <= 1'b1;
      cmd_write  <= 1'b0;
      cmd_addr   <= '0;
      count      <= '0;
      staging    <= '0;
      tx_shift   <= '0;
      upd        <= 1'b0;
      frame_err  <= 1'b0;
      sticky_err <= 1'b0;
    end else begin
      cs_prev   <= cs_active;
      upd       <= commit;
      frame_err <= abort;
      if (abort)       sticky_err <= 1'b1;
      else if (commit) sticky_err <= 1'b0;

      if (state_q == ST_CMD && byte_evt) begin
        cmd_write <= rx_byte[CMD_WRITE_BIT];
        cmd_addr  <= rx_byte[CMD_ADDR_MSB:0];
        count     <= '0;
        staging   <= '0;
        tx_shift  <= rx_byte[CMD_WRITE_BIT] ? '0 : rd_data;
      end else if (state_q == ST_DATA && byte_evt) begin
        staging  <= {staging[FW_W-9:0], rx_byte};
        count    <= count + 2'd1;
        tx_shift <= {tx_shift[FW_W-9:0], 8'h00};
      end else if (state_q == ST_DONE && byte_evt) begin
        tx_shift <= {tx_shift[FW_W-9:0], 8'h00};
      end
    end
  end

  // The read address comes straight from the command byte so the first
  // readback byte is ready the cycle after the command is accepted.
  spi_reg_bank #(
    .FW_W         (FW_W),
    .FREQ_DEFAULT (FREQ_DEFAULT),
    .SYM_DEFAULT  (SYM_DEFAULT),
    .ID_VALUE     (ID_VALUE)
  ) u_bank (
    .clk          (clk),
    .rst          (rst),
    .we           (commit),
    .wr_addr      (cmd_addr),
    .wr_data      (staging),
    .rd_addr      (rx_byte[CMD_ADDR_MSB:0]),
    .rd_data      (rd_data),
    .freq_word1   (freq_word1),
    .freq_word2   (freq_word2),
    .phase_word1  (phase_word1),
    .phase_word2  (phase_word2),
    .triangle_sym (triangle_sym),
    .ctrl         (ctrl)
  );

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
Command decoder and register bank between the SPI slave byte interface and the two DDS channels. Parses byte frames from the SPI slave (command byte plus 4 data bytes) and supports register readback. Drives the frequency, phase, triangle-symmetry and control words consumed by the DDS instances. Writes are staged in shadow registers and committed atomically at frame end, so the DDS never sees a half-written 32-bit word.

Parameters:
FW_W, 32, width of frequency/phase/symmetry words
FREQ_DEFAULT, 2147483, reset value of FREQ1/FREQ2
SYM_DEFAULT, 154748364, reset value of TRI_SYM
ID_VALUE, 32'h44504F31, read-only ID register contents

Ports:
clk  in  1  system clock (PLL clkout0 domain)
rst  in  1  synchronous reset, active-high
cs_active  in  1  SPI chip select asserted, already synchronised to clk
rx_byte  in  8  byte received from SPI slave
rx_valid  in  1  one-cycle strobe, rx_byte valid
tx_byte  out  8  byte the SPI slave shifts out on the next transfer
freq_word1  out  FW_W  DDS channel 1 frequency word
freq_word2  out  FW_W  DDS channel 2 frequency word
phase_word1  out  FW_W  channel 1 phase offset
phase_word2  out  FW_W  channel 2 phase offset
triangle_sym  out  FW_W  channel 2 triangle symmetry
ctrl  out  8  bit0 ch1 enable, bit1 ch2 enable, bits[7:2] reserved
upd  out  1  one-cycle pulse when a commit changes the outputs
frame_err  out  1  one-cycle pulse at end of a malformed frame

Behaviour:
- Reset (rst high at a clk edge): freq_word1/2 = FREQ_DEFAULT; phase_word1/2 = 0; triangle_sym = SYM_DEFAULT; ctrl = 8'h03; tx_byte = 0; upd = 0; frame_err = 0; FSM to IDLE. Reset mid-frame discards the frame with no commit.
- Command byte: bit7 = 1 write, 0 read; bits[6:4] ignored; bits[3:0] = address.
- Register map: 0 FREQ1, 1 FREQ2, 2 PHASE1, 3 PHASE2, 4 TRI_SYM, 5 CTRL (low 8 bits used), 6 ID (read-only). Addresses 7-15: writes ignored, reads return 0.
- Data bytes are MSB first.
- rx_valid is ignored while cs_active is low.
- FSM states: IDLE, CMD, DATA, DONE.
  - IDLE -> CMD when cs_active rises.
  - CMD: first rx_valid latches the command, clears byte count, -> DATA.
  - DATA: each rx_valid shifts rx_byte into a 32-bit staging register and increments the count. After the 4th byte -> DONE.
  - DONE: further bytes are ignored. They do not make the frame an error.
  - Any state -> IDLE when cs_active falls.
- Commit: cs_active falls while in DONE with a write command to a writable address -> staging value is loaded into the addressed output on the next cycle, with upd = 1 on that same cycle. CTRL takes staging[7:0].
- No commit and frame_err pulse when cs_active falls in CMD after at least one byte, or in DATA. A frame with zero bytes is silent.
- Write to ID or an unmapped address completes without commit, upd or frame_err.
- Readback:
  - The cycle after the command byte is accepted, tx_byte = bits[31:24] of the addressed live register.
  - After each following rx_valid, tx_byte advances to bits[23:16], [15:8], [7:0], then 0x00.
  - Write commands return 0x00 bytes.
  - In IDLE and CMD, tx_byte = {7'b0, sticky_err}; sticky_err is set by frame_err and cleared by any successful commit.
- Outputs change only at commit or reset; they never glitch mid-frame.

Decomposition:
- Package spi_reg_pkg: address constants (ADDR_FREQ1 to ADDR_ID), command bit positions, default values, FSM state encoding.
- One sub-module, spi_reg_bank: live registers, commit write port and read mux. The frame parser FSM stays in spi_reg_ctrl.

Test Plan:
- Reset, then no traffic -> freq_word1 = freq_word2 = 2147483, triangle_sym = 154748364, ctrl = 8'h03, upd = 0.
- Frame 0x80,0x00,0x10,0x00,0x00 then cs_active low -> freq_word1 = 32'h00100000 one cycle after cs falls, upd pulses once, freq_word2 unchanged.
- Frame 0x06 followed by four dummy bytes -> tx_byte sequence 0x44,0x50,0x4F,0x31,0x00.
- Write frame to address 1 aborted after 2 data bytes -> freq_word2 stays 2147483, frame_err pulses once, next idle tx_byte = 0x01.
- Write to address 6 with 6 data bytes -> no commit, no frame_err, ID readback still 32'h44504F31.
- rst asserted during DATA of a FREQ1 write, then frame completed -> no commit, outputs equal reset values.
